// File: rtl/mult_div_unit.sv
// mult_div_unit: HI/LO multiply/divide unit beside the E-stage ALU.
// Results are computed at the Start edge and held in pending registers.
// They are committed to HI/LO after a fixed busy period.
// Optional build macro MDU_MADD_EN enables madd/maddu/msub/msubu (MDOp 7-10).
//
// state | meaning
// IDLE  | Busy=0, accepts a new op on Start
// BUSY  | Busy=1, counter>0, commits pending result when counter goes 1->0
module mult_div_unit #(
  parameter int WIDTH       = 32,
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10,
  parameter int CNT_W       = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             Start,
  input  logic [3:0]       MDOp,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             Busy,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO
);

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MTHI  = 4'd5;
  localparam logic [3:0] OP_MTLO  = 4'd6;
`ifdef MDU_MADD_EN
  localparam logic [3:0] OP_MADD  = 4'd7;
  localparam logic [3:0] OP_MADDU = 4'd8;
  localparam logic [3:0] OP_MSUB  = 4'd9;
  localparam logic [3:0] OP_MSUBU = 4'd10;
`endif

  localparam logic [CNT_W-1:0] MULT_LD = CNT_W'(MULT_CYCLES);
  localparam logic [CNT_W-1:0] DIV_LD  = CNT_W'(DIV_CYCLES);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t             state, state_n;
  logic [CNT_W-1:0]   cnt, cnt_n;
  logic [WIDTH-1:0]   p_hi, p_hi_n, p_lo, p_lo_n;
  logic               p_wr, p_wr_n;
  logic [WIDTH-1:0]   hi_q, hi_n, lo_q, lo_n;

  logic [2*WIDTH-1:0] prod_s, prod_u;
  logic [WIDTH-1:0]   abs_a, abs_b, div_bs, div_bu;
  logic [WIDTH-1:0]   q_mag, r_mag, quo_s, rem_s, quo_u, rem_u;
  logic               b_zero;

  // Low 2*WIDTH bits of the sign-extended product equal the signed product.
  assign prod_s = {{WIDTH{A[WIDTH-1]}}, A} * {{WIDTH{B[WIDTH-1]}}, B};
  assign prod_u = {{WIDTH{1'b0}}, A} * {{WIDTH{1'b0}}, B};

  // Signed division via magnitudes, so min-int / -1 wraps to min-int.
  // The divisor is forced to 1 on zero; the result is discarded anyway.
  assign b_zero = (B == '0);
  assign abs_a  = A[WIDTH-1] ? -A : A;
  assign abs_b  = B[WIDTH-1] ? -B : B;
  assign div_bs = b_zero ? WIDTH'(1) : abs_b;
  assign div_bu = b_zero ? WIDTH'(1) : B;
  assign q_mag  = abs_a / div_bs;
  assign r_mag  = abs_a % div_bs;
  assign quo_s  = (A[WIDTH-1] ^ B[WIDTH-1]) ? -q_mag : q_mag;
  assign rem_s  = A[WIDTH-1] ? -r_mag : r_mag;
  assign quo_u  = A / div_bu;
  assign rem_u  = A % div_bu;

`ifdef MDU_MADD_EN
  logic [2*WIDTH-1:0] acc;
  assign acc = {hi_q, lo_q};
`endif

  // Next-state, counter, pending result and HI/LO update decisions.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    p_hi_n  = p_hi;
    p_lo_n  = p_lo;
    p_wr_n  = p_wr;
    hi_n    = hi_q;
    lo_n    = lo_q;
    case (state)
      IDLE: begin
        if (Start) begin
          case (MDOp)
            OP_MULT: begin
              {p_hi_n, p_lo_n} = prod_s;
              p_wr_n = 1'b1; cnt_n = MULT_LD; state_n = BUSY;
            end
            OP_MULTU: begin
              {p_hi_n, p_lo_n} = prod_u;
              p_wr_n = 1'b1; cnt_n = MULT_LD; state_n = BUSY;
            end
            OP_DIV: begin
              p_hi_n = rem_s; p_lo_n = quo_s;
              p_wr_n = ~b_zero; cnt_n = DIV_LD; state_n = BUSY;
            end
            OP_DIVU: begin
              p_hi_n = rem_u; p_lo_n = quo_u;
              p_wr_n = ~b_zero; cnt_n = DIV_LD; state_n = BUSY;
            end
            OP_MTHI: hi_n = A;
            OP_MTLO: lo_n = A;
`ifdef MDU_MADD_EN
            OP_MADD: begin
              {p_hi_n, p_lo_n} = acc + prod_s;
              p_wr_n = 1'b1; cnt_n = MULT_LD; state_n = BUSY;
            end
            OP_MADDU: begin
              {p_hi_n, p_lo_n} = acc + prod_u;
              p_wr_n = 1'b1; cnt_n = MULT_LD; state_n = BUSY;
            end
            OP_MSUB: begin
              {p_hi_n, p_lo_n} = acc - prod_s;
              p_wr_n = 1'b1; cnt_n = MULT_LD; state_n = BUSY;
            end
            OP_MSUBU: begin
              {p_hi_n, p_lo_n} = acc - prod_u;
              p_wr_n = 1'b1; cnt_n = MULT_LD; state_n = BUSY;
            end
`endif
            default: ;
          endcase
        end
      end
      BUSY: begin
        cnt_n = cnt - CNT_W'(1);
        if (cnt == CNT_W'(1)) begin
          state_n = IDLE;
          p_wr_n  = 1'b0;
          if (p_wr) begin
            hi_n = p_hi;
            lo_n = p_lo;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // State, counter, pending and architectural registers; reset dominates.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
      p_hi  <= '0;
      p_lo  <= '0;
      p_wr  <= 1'b0;
      hi_q  <= '0;
      lo_q  <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      p_hi  <= p_hi_n;
      p_lo  <= p_lo_n;
      p_wr  <= p_wr_n;
      hi_q  <= hi_n;
      lo_q  <= lo_n;
    end
  end

  assign Busy = (state == BUSY);
  assign HI   = hi_q;
  assign LO   = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit (default parameters, WIDTH=32).
module tb_mult_div_unit;

  logic        clk;
  logic        reset;
  logic        Start;
  logic [3:0]  MDOp;
  logic [31:0] A, B;
  logic        Busy;
  logic [31:0] HI, LO;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a, b;
    logic [31:0] hi, lo;
    int          cyc;
  } vec_t;

  typedef struct {
    logic [31:0] hi, lo;
    int          cyc;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];

  mult_div_unit dut (
    .clk(clk), .reset(reset), .Start(Start), .MDOp(MDOp),
    .A(A), .B(B), .Busy(Busy), .HI(HI), .LO(LO)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic add(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                     input logic [31:0] hi, input logic [31:0] lo, input int cyc);
    vec_t v;
    v.op = op; v.a = a; v.b = b; v.hi = hi; v.lo = lo; v.cyc = cyc;
    vecs.push_back(v);
  endtask

  // Issue one op, watch the busy period, then compare against the scoreboard.
  task automatic run_op(input string name, input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] hi, input logic [31:0] lo,
                        input int cyc);
    exp_t e;
    exp_t got;
    logic [31:0] hold_hi, hold_lo;
    int n;
    e.hi = hi; e.lo = lo; e.cyc = cyc;
    sb.push_back(e);
    hold_hi = HI; hold_lo = LO;
    @(negedge clk);
    Start = 1'b1; MDOp = op; A = a; B = b;
    @(negedge clk);
    Start = 1'b0; MDOp = 4'd0;
    n = 0;
    while (Busy && n < 100) begin
      check({name, "_hold_hi"}, HI, hold_hi);
      check({name, "_hold_lo"}, LO, hold_lo);
      n++;
      @(negedge clk);
    end
    if (n >= 100) begin
      errors++;
      $display("FAIL %s_timeout busy still high after %0d cycles", name, n);
    end
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL %s_scoreboard empty queue", name);
    end else begin
      got = sb.pop_front();
      check({name, "_busy_cycles"}, 32'(n), 32'(got.cyc));
      check({name, "_hi"}, HI, got.hi);
      check({name, "_lo"}, LO, got.lo);
    end
  endtask

  initial begin
    int n;
    reset = 1'b1; Start = 1'b0; MDOp = 4'd0; A = '0; B = '0;

    add(4'd1, 32'hFFFFFFFD, 32'd5,        32'hFFFFFFFF, 32'hFFFFFFF1, 5);
    add(4'd2, 32'hFFFFFFFF, 32'd2,        32'h00000001, 32'hFFFFFFFE, 5);
    add(4'd3, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 10);
    add(4'd5, 32'h12345678, 32'd0,        32'h12345678, 32'hFFFFFFFD, 0);
    add(4'd4, 32'd100,      32'd0,        32'h12345678, 32'hFFFFFFFD, 10);
    add(4'd3, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 10);
    add(4'd4, 32'd100,      32'd7,        32'h00000002, 32'h0000000E, 10);
    add(4'd6, 32'h0000CAFE, 32'd0,        32'h00000002, 32'h0000CAFE, 0);
    add(4'd0, 32'd1,        32'd1,        32'h00000002, 32'h0000CAFE, 0);
    add(4'd11, 32'd1,       32'd1,        32'h00000002, 32'h0000CAFE, 0);
    add(4'd3, 32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 10);
    add(4'd1, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h3FFFFFFF, 32'h00000001, 5);
    add(4'd5, 32'h00000000, 32'd0,        32'h00000000, 32'h00000001, 0);
    add(4'd6, 32'hFFFFFFFF, 32'd0,        32'h00000000, 32'hFFFFFFFF, 0);
`ifdef MDU_MADD_EN
    add(4'd8, 32'd1,        32'd1,        32'h00000001, 32'h00000000, 5);
    add(4'd9, 32'hFFFFFFFF, 32'd2,        32'h00000001, 32'h00000002, 5);
    add(4'd10, 32'd1,       32'd3,        32'h00000000, 32'hFFFFFFFF, 5);
`else
    add(4'd8, 32'd1,        32'd1,        32'h00000000, 32'hFFFFFFFF, 0);
    add(4'd9, 32'hFFFFFFFF, 32'd2,        32'h00000000, 32'hFFFFFFFF, 0);
    add(4'd10, 32'd1,       32'd3,        32'h00000000, 32'hFFFFFFFF, 0);
`endif

    repeat (3) @(negedge clk);
    reset = 1'b0;
    check("reset_busy", 32'(Busy), 32'd0);
    check("reset_hi", HI, 32'd0);
    check("reset_lo", LO, 32'd0);

    for (int i = 0; i < vecs.size(); i++)
      run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b,
             vecs[i].hi, vecs[i].lo, vecs[i].cyc);

    // Start pulses during a mult busy period, including the last busy cycle.
    @(negedge clk);
    Start = 1'b1; MDOp = 4'd1; A = 32'd3; B = 32'd4;
    @(negedge clk);
    Start = 1'b0; MDOp = 4'd0;
    n = 0;
    while (Busy && n < 100) begin
      n++;
      if (n == 2) begin
        Start = 1'b1; MDOp = 4'd6; A = 32'h0000DEAD;
      end else if (n == 3) begin
        Start = 1'b1; MDOp = 4'd3; A = 32'd100; B = 32'd3;
      end else if (n == 5) begin
        Start = 1'b1; MDOp = 4'd5; A = 32'h00005555;
      end else begin
        Start = 1'b0; MDOp = 4'd0;
      end
      @(negedge clk);
    end
    Start = 1'b0; MDOp = 4'd0;
    check("ignore_busy_cycles", 32'(n), 32'd5);
    check("ignore_hi", HI, 32'd0);
    check("ignore_lo", LO, 32'd12);
    check("ignore_idle_after", 32'(Busy), 32'd0);

    // New op accepted on the first idle cycle after Busy falls.
    run_op("b2b_mthi", 4'd5, 32'h00000777, 32'd0, 32'h00000777, 32'd12, 0);

    // Reset in the middle of a divide.
    @(negedge clk);
    Start = 1'b1; MDOp = 4'd3; A = 32'd100; B = 32'd7;
    @(negedge clk);
    Start = 1'b0; MDOp = 4'd0;
    repeat (3) @(negedge clk);
    check("mid_div_busy", 32'(Busy), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("rst_mid_busy", 32'(Busy), 32'd0);
    check("rst_mid_hi", HI, 32'd0);
    check("rst_mid_lo", LO, 32'd0);
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      check("no_late_write", HI | LO | 32'(Busy), 32'd0);
    end
    run_op("post_rst_multu", 4'd2, 32'd3, 32'd4, 32'd0, 32'd12, 5);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
